// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register.
// Optional parity storage is enabled with PIPE_REG_PARITY_EN.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int clog2_depth(input int depth);
    int n;
    n = 0;
    while ((1 << n) < (depth + 1)) begin
      n++;
    end
    return (n < 1) ? 1 : n;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
`ifdef PIPE_REG_PARITY_EN
    logic                     par;
`endif
  } stage_t;

endpackage

// File: rtl/pipe_reg_stage.sv
// One elastic stage: holds a beat until the downstream side is ready.
// Carries a parity bit alongside the data when PIPE_REG_PARITY_EN is defined.
module pipe_reg_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
`ifdef PIPE_REG_PARITY_EN
  input  logic             src_par,
  output logic             p,
`endif
  input  logic             dst_ready,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             r
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
`ifdef PIPE_REG_PARITY_EN
  logic             p_q, p_d;
`endif

  // An empty stage can always take a beat, even while downstream stalls.
  assign r = !v_q || dst_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
`ifdef PIPE_REG_PARITY_EN
    p_d = p_q;
`endif
    if (flush) begin
      v_d = 1'b0;
    end else if (r) begin
      v_d = src_valid;
      if (src_valid) begin
        d_d = src_data;
`ifdef PIPE_REG_PARITY_EN
        p_d = src_par;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      v_q <= 1'b0;
      d_q <= '0;
`ifdef PIPE_REG_PARITY_EN
      p_q <= 1'b0;
`endif
    end else begin
      v_q <= v_d;
      d_q <= d_d;
`ifdef PIPE_REG_PARITY_EN
      p_q <= p_d;
`endif
    end
  end

  assign v = v_q;
  assign d = d_q;
`ifdef PIPE_REG_PARITY_EN
  assign p = p_q;
`endif

endmodule

// File: rtl/pipe_reg_elastic.sv
// DEPTH-stage elastic pipeline register with valid/ready on both sides,
// flush and occupancy count. PIPE_REG_PARITY_EN adds per-stage parity and parity_err.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = 3,
  localparam int CW    = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_REG_PARITY_EN
  output logic             parity_err,
`endif
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_w;
  logic [WIDTH-1:0] d_w [DEPTH];
  logic [DEPTH:0]   r_w;
`ifdef PIPE_REG_PARITY_EN
  logic [DEPTH-1:0] par_w;
`endif
  logic             accept;
  logic             emit;
  logic [CW-1:0]    count_q, count_d;

  assign r_w[DEPTH] = out_ready;
  assign in_ready   = r_w[0] && !flush;
  assign accept     = in_valid && in_ready;
  assign emit       = out_valid && out_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;
`ifdef PIPE_REG_PARITY_EN
      logic             src_par;
`endif
      if (gi == 0) begin : g_head
        assign src_valid = accept;
        assign src_data  = in_data;
`ifdef PIPE_REG_PARITY_EN
        assign src_par   = ^in_data;
`endif
      end else begin : g_body
        assign src_valid = v_w[gi-1];
        assign src_data  = d_w[gi-1];
`ifdef PIPE_REG_PARITY_EN
        assign src_par   = par_w[gi-1];
`endif
      end

      pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .res       (res),
        .flush     (flush),
        .src_valid (src_valid),
        .src_data  (src_data),
`ifdef PIPE_REG_PARITY_EN
        .src_par   (src_par),
        .p         (par_w[gi]),
`endif
        .dst_ready (r_w[gi+1]),
        .v         (v_w[gi]),
        .d         (d_w[gi]),
        .r         (r_w[gi])
      );
    end
  endgenerate

  assign out_valid = v_w[DEPTH-1];
  assign out_data  = d_w[DEPTH-1];
`ifdef PIPE_REG_PARITY_EN
  assign parity_err = out_valid && ((^out_data) != par_w[DEPTH-1]);
`endif

  // Flush empties every stage, so occupancy drops to zero regardless of an emit.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (accept && !emit) begin
      count_d = count_q + CW'(1);
    end else if (emit && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
